// File: rtl/tt_capture_seq.sv
// tt_capture_seq: sequential truth-table capture for a 4-input, 1-output
// function block. Walks x through minterms 0..15, holds each for
// SETTLE_CYCLES+1 cycles, samples y on the last cycle into tt[m], then offers
// the finished 16-bit table downstream over a valid/ready handshake.
// Optional build macro TT_CAPTURE_CHECK_EN adds tt_expect/tt_match, a
// registered comparison of the finished table against an expected table.
module tt_capture_seq #(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [3:0]  x,
  input  logic        y,
  output logic [15:0] tt,
  output logic        tt_valid,
`ifdef TT_CAPTURE_CHECK_EN
  input  logic [15:0] tt_expect,
  output logic        tt_match,
`endif
  input  logic        tt_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Wait-counter value on which the current minterm is sampled (range 0..15).
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  w_q, w_d;
  logic [3:0]  x_q, x_d;
  logic [15:0] tt_q, tt_d;
  logic        tt_valid_q, tt_valid_d;
  logic        busy_q, busy_d;
`ifdef TT_CAPTURE_CHECK_EN
  logic        tt_match_q, tt_match_d;
`endif

  // Next-state logic: minterm stepping, settle counting, sampling, handshake.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    w_d     = w_q;
    x_d     = x_q;
    tt_d    = tt_q;
`ifdef TT_CAPTURE_CHECK_EN
    tt_match_d = tt_match_q;
`endif
    case (state_q)
      IDLE: begin
        x_d = 4'd0;
        if (start) begin
          state_d = DRIVE;
          m_d     = 4'd0;
          w_d     = 4'd0;
          x_d     = 4'd0;
          tt_d    = 16'h0000;
`ifdef TT_CAPTURE_CHECK_EN
          tt_match_d = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if (w_q != SETTLE_LAST) begin
          w_d = w_q + 4'd1;
        end else begin
          // y has had SETTLE_CYCLES+1 cycles to settle for minterm m.
          tt_d[m_q] = y;
          w_d       = 4'd0;
          if (m_q == 4'd15) begin
            state_d = DONE;
            x_d     = 4'd0;
`ifdef TT_CAPTURE_CHECK_EN
            // Compare includes the bit captured on this very edge.
            tt_match_d = (tt_d == tt_expect);
`endif
          end else begin
            m_d = m_q + 4'd1;
            x_d = m_q + 4'd1;
          end
        end
      end
      DONE: begin
        x_d = 4'd0;
        // start is deliberately not looked at here, even on the handshake edge.
        if (tt_ready) begin
          state_d = IDLE;
          m_d     = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = 4'd0;
      end
    endcase
    tt_valid_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset aborts any run and discards the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= 4'd0;
      w_q        <= 4'd0;
      x_q        <= 4'd0;
      tt_q       <= 16'h0000;
      tt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TT_CAPTURE_CHECK_EN
      tt_match_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      w_q        <= w_d;
      x_q        <= x_d;
      tt_q       <= tt_d;
      tt_valid_q <= tt_valid_d;
      busy_q     <= busy_d;
`ifdef TT_CAPTURE_CHECK_EN
      tt_match_q <= tt_match_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign x        = x_q;
  assign tt       = tt_q;
  assign tt_valid = tt_valid_q;
`ifdef TT_CAPTURE_CHECK_EN
  assign tt_match = tt_match_q;
`endif

endmodule

// File: tb/tb_tt_capture_seq.sv
// Bench for tt_capture_seq: two instances (SETTLE_CYCLES 0 and 2) share all
// control stimulus. A behavioural model predicts every output each cycle from
// elapsed-edge arithmetic; literal tables and latencies pin the model.
module tb_tt_capture_seq;

  localparam int S0 = 0;
  localparam int S1 = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tt_ready;
  logic        noise_bit;
  int          fsel;
  logic [15:0] rand_tab;

  logic [1:0]       busy_w;
  logic [1:0]       tt_valid_w;
  logic [1:0]       y_w;
  logic [1:0]       sample_now;
  logic [1:0][3:0]  x_w;
  logic [1:0][15:0] tt_w;
`ifdef TT_CAPTURE_CHECK_EN
  logic [15:0] tt_expect;
  logic [1:0]  tt_match_w;
  logic        lit_match;
  logic        mmatch [2];
`endif

  // Reference model: phase 0 idle, 1 driving, 2 table offered; e counts edges since accept.
  int          ph  [2];
  int          e   [2];
  logic [15:0] mtt [2];

  int          vectors;
  int          miscompares;
  int          tmo_req;
  int          tmo_seen;
  logic        lit_en;
  logic [15:0] lit_tt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under characterisation, selected by the stimulus.
  function automatic logic fval(input int sel, input logic [3:0] m, input logic [15:0] tab);
    case (sel)
      0:       return m[0];
      1:       return m[3];
      2:       return m[0] & m[1];
      3:       return 1'b0;
      4:       return 1'b1;
      5:       return m[0] ^ m[1];
      default: return tab[m];
    endcase
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int S = (gi == 0) ? S0 : S1;
      // y glitches freely except when the model says this edge samples.
      assign sample_now[gi] = (ph[gi] == 1) && ((e[gi] % (S + 1)) == S);
      assign y_w[gi] = fval(fsel, x_w[gi], rand_tab) ^ (noise_bit & ~sample_now[gi]);

      tt_capture_seq #(.SETTLE_CYCLES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy_w[gi]),
        .x         (x_w[gi]),
        .y         (y_w[gi]),
        .tt        (tt_w[gi]),
        .tt_valid  (tt_valid_w[gi]),
`ifdef TT_CAPTURE_CHECK_EN
        .tt_expect (tt_expect),
        .tt_match  (tt_match_w[gi]),
`endif
        .tt_ready  (tt_ready)
      );
    end
  endgenerate

  // Model update on each clock edge or reset assertion.
  initial begin
    int s;
    int ph_n;
    int e_n;
    logic [15:0] t_n;
`ifdef TT_CAPTURE_CHECK_EN
    logic m_n;
`endif
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; e[i] = 0; mtt[i] = 16'h0000;
`ifdef TT_CAPTURE_CHECK_EN
      mmatch[i] = 1'b0;
`endif
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        s = settle_of(i);
        ph_n = ph[i]; e_n = e[i]; t_n = mtt[i];
`ifdef TT_CAPTURE_CHECK_EN
        m_n = mmatch[i];
`endif
        if (rst) begin
          ph_n = 0; e_n = 0; t_n = 16'h0000;
`ifdef TT_CAPTURE_CHECK_EN
          m_n = 1'b0;
`endif
        end else if (ph[i] == 0) begin
          if (start) begin
            ph_n = 1; e_n = 0; t_n = 16'h0000;
`ifdef TT_CAPTURE_CHECK_EN
            m_n = 1'b0;
`endif
          end
        end else if (ph[i] == 1) begin
          if ((e[i] % (s + 1)) == s)
            t_n[e[i] / (s + 1)] = fval(fsel, 4'(e[i] / (s + 1)), rand_tab);
          e_n = e[i] + 1;
          if (e_n == 16 * (s + 1)) begin
            ph_n = 2;
`ifdef TT_CAPTURE_CHECK_EN
            m_n = (t_n == tt_expect);
`endif
          end
        end else if (tt_ready) begin
          ph_n = 0;
        end
        ph[i]  <= ph_n;
        e[i]   <= e_n;
        mtt[i] <= t_n;
`ifdef TT_CAPTURE_CHECK_EN
        mmatch[i] <= m_n;
`endif
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d (settle %0d) at %0t: got %0h expected %0h",
               name, inst, settle_of(inst), $time, act, exp);
    end
  endtask

  // Compare process: every falling edge, both instances.
  initial begin
    logic prev_busy [2];
    logic prev_valid [2];
    int   lat [2];
    int   s;
    vectors = 0; miscompares = 0; tmo_seen = 0;
    for (int i = 0; i < 2; i++) begin
      prev_busy[i] = 1'b0; prev_valid[i] = 1'b0; lat[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s = settle_of(i);
        if (rst) begin
          chk("reset_busy", i, 32'(busy_w[i]), 32'd0);
          chk("reset_x", i, 32'(x_w[i]), 32'd0);
          chk("reset_tt", i, 32'(tt_w[i]), 32'd0);
          chk("reset_tt_valid", i, 32'(tt_valid_w[i]), 32'd0);
`ifdef TT_CAPTURE_CHECK_EN
          chk("reset_tt_match", i, 32'(tt_match_w[i]), 32'd0);
`endif
          prev_busy[i] = 1'b0; prev_valid[i] = 1'b0; lat[i] = 0;
        end else begin
          chk("busy", i, 32'(busy_w[i]), 32'(ph[i] != 0));
          chk("x", i, 32'(x_w[i]), (ph[i] == 1) ? 32'(e[i] / (s + 1)) : 32'd0);
          chk("tt", i, 32'(tt_w[i]), 32'(mtt[i]));
          chk("tt_valid", i, 32'(tt_valid_w[i]), 32'(ph[i] == 2));
`ifdef TT_CAPTURE_CHECK_EN
          chk("tt_match", i, 32'(tt_match_w[i]), 32'(mmatch[i]));
`endif
          if (busy_w[i] && !prev_busy[i]) lat[i] = 0;
          else if (busy_w[i]) lat[i]++;
          if (tt_valid_w[i] && !prev_valid[i]) begin
            chk("latency", i, 32'(lat[i]), (i == 0) ? 32'd16 : 32'd48);
            if (lit_en) begin
              chk("tt_literal", i, 32'(tt_w[i]), 32'(lit_tt));
`ifdef TT_CAPTURE_CHECK_EN
              chk("tt_match_literal", i, 32'(tt_match_w[i]), 32'(lit_match));
`endif
            end
          end
          prev_busy[i] = busy_w[i];
          prev_valid[i] = tt_valid_w[i];
        end
      end
      while (tmo_seen != tmo_req) begin
        tmo_seen++;
        vectors++;
        miscompares++;
        $display("FAIL timeout at %0t: got no expected DUT event, required one within its cycle budget", $time);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    noise_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int max);
    int c;
    c = 0;
    while (busy_w != 2'b00 && c < max) begin tick(); c++; end
    if (busy_w != 2'b00) tmo_req++;
  endtask

  task automatic run_one(input int f, input logic [15:0] lit);
    fsel = f; lit_tt = lit; lit_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_idle(200);
    tick();
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int c;
    rst = 1'b1; start = 1'b0; tt_ready = 1'b1; noise_bit = 1'b0;
    fsel = 0; rand_tab = 16'h0000; lit_en = 1'b0; lit_tt = 16'h0000; tmo_req = 0;
`ifdef TT_CAPTURE_CHECK_EN
    tt_expect = 16'h0000; lit_match = 1'b0;
`endif
    repeat (3) tick();
    #1 rst = 1'b0;

    run_one(0, 16'hAAAA);
    run_one(1, 16'hFF00);

    // Downstream stalls; start pulses while the table is offered are ignored.
    fsel = 2; lit_tt = 16'h8888; lit_en = 1'b1; tt_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (tt_valid_w != 2'b11 && c < 100) begin tick(); c++; end
    if (tt_valid_w != 2'b11) tmo_req++;
    for (int k = 0; k < 5; k++) begin start = (k % 2 == 0); tick(); end
    start = 1'b0; tt_ready = 1'b1;
    tick(); tick();
    wait_idle(10);

    // Reset lands while instance 0 holds minterm 7; checked before the next rising edge.
    fsel = 0; lit_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (x_w[0] != 4'd6 && c < 40) begin tick(); c++; end
    if (x_w[0] != 4'd6) tmo_req++;
    @(posedge clk); #1 rst = 1'b1;
    tick(); #1 rst = 1'b0;
    run_one(3, 16'h0000);

    // start held high: back-to-back runs.
    fsel = 4; lit_tt = 16'hFFFF; lit_en = 1'b1; tt_ready = 1'b1;
    start = 1'b1; repeat (160) tick(); start = 1'b0;
    wait_idle(100); tick();

`ifdef TT_CAPTURE_CHECK_EN
    tt_expect = 16'h6666; lit_match = 1'b1;
`endif
    run_one(5, 16'h6666);
`ifdef TT_CAPTURE_CHECK_EN
    tt_expect = 16'h6667; lit_match = 1'b0;
`endif
    run_one(5, 16'h6666);

    // Randomized traffic with occasional asynchronous reset.
    lit_en = 1'b0;
    for (int b = 0; b < 6; b++) begin
      rand_tab = 16'($urandom);
      fsel = $urandom_range(0, 6);
      for (int k = 0; k < 400; k++) begin
        start = ($urandom_range(0, 3) == 0);
        tt_ready = 1'($urandom_range(0, 1));
`ifdef TT_CAPTURE_CHECK_EN
        tt_expect = ($urandom_range(0, 1) == 1) ? rand_tab : 16'($urandom);
`endif
        if ($urandom_range(0, 299) == 0) begin
          @(posedge clk); #1 rst = 1'b1;
          tick(); #1 rst = 1'b0;
        end else begin
          tick();
        end
      end
    end
    start = 1'b0; tt_ready = 1'b1;
    wait_idle(200);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_capture_seq.md
Name: tt_capture_seq

Overview:
- Sequential truth-table capture stage for a 4-input, 1-output combinational function block.
- Sits directly upstream of the function: drives all 16 input minterms onto its inputs x0..x3 in order, waits a programmable settle time, samples its output y0, and assembles a 16-bit truth table.
- Delivers the table downstream through a valid/ready handshake.
- Used to characterise each function block and to check it against its intended class.

Parameters:
- SETTLE_CYCLES, 0, extra cycles a minterm is held on x before y is sampled. Range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one capture run; accepted only in IDLE.
- busy  output  1  high whenever state is not IDLE.
- x  output  4  minterm driven to the function; x[0] feeds x0 ... x[3] feeds x3.
- y  input  1  function output y0; combinational from x.
- tt  output  16  captured table; tt[m] = y sampled while x == m.
- tt_valid  output  1  tt is complete and stable.
- tt_ready  input  1  downstream accepts tt.

Behaviour:
- Reset (async assert, released synchronously to clk): state IDLE, x=0, tt=16'h0000, tt_valid=0, busy=0, minterm counter m=0, wait counter w=0.
- All outputs are registered.

States:
- IDLE
  - x=0, tt_valid=0. tt keeps its last value.
  - start=1 -> DRIVE, with m=0, x=0, w=0, tt cleared to 0.
- DRIVE
  - Each edge with w < SETTLE_CYCLES: w++.
  - Edge with w == SETTLE_CYCLES: tt[m] <= y.
    - If m == 15: -> DONE, tt_valid=1, x=0.
    - Otherwise: m++, x <= m+1, w=0.
  - Each minterm is therefore held on x for exactly SETTLE_CYCLES+1 cycles.
- DONE
  - tt_valid=1; tt and x=0 held stable.
  - tt_valid && tt_ready at an edge -> IDLE, tt_valid=0 on the next cycle.
  - tt_ready may be high before tt_valid. With tt_ready tied high, tt_valid lasts exactly 1 cycle.

Timing and rules:
- Latency: tt_valid rises 16*(SETTLE_CYCLES+1) edges after the start-accept edge. With SETTLE_CYCLES=0, that is 16 edges.
- start is ignored while busy, including the edge that completes the handshake. A new run needs start in IDLE.
- m wraps only by the return to IDLE; the counter never increments past 15.
- Reset asserted mid-run: immediate abort to the reset values. The partial tt is discarded (cleared) and no tt_valid is produced.
- y is sampled only at the DRIVE sample edge. Glitches on y at other times have no effect.

Optional Feature:
- Macro: TT_CAPTURE_CHECK_EN.
- When defined, the block adds:
  - input tt_expect[15:0].
  - output tt_match (1 bit), registered and updated on the same edge that sets tt_valid, equal to (tt == tt_expect) using tt_expect sampled on that edge.
  - tt_match holds until the next start is accepted, then clears to 0. Reset value 0.
- When not defined, tt_expect and tt_match do not exist and behaviour is otherwise identical.

Test Plan:
- SETTLE_CYCLES=0, y=x[0], tt_ready=1, pulse start -> x steps 0..15 one per cycle, tt_valid high 16 edges after start for 1 cycle, tt=16'hAAAA.
- SETTLE_CYCLES=2, y=x[3] -> each x value held 3 cycles, tt_valid after 48 edges, tt=16'hFF00.
- y = x[0]&x[1] with tt_ready=0 for 5 cycles after tt_valid -> tt=16'h8888 stable, tt_valid held; start pulses during DONE ignored; IDLE one cycle after tt_ready=1.
- Assert rst while m=7 -> x=0, tt=0, busy=0, tt_valid=0 immediately. A subsequent start with y=0 gives tt=16'h0000 after 16 edges.
- Constant y=1, start held high continuously -> back-to-back runs each producing tt=16'hFFFF, separated by one IDLE cycle.
- With TT_CAPTURE_CHECK_EN and y=x[0]^x[1]: tt_expect=16'h6666 gives tt_match=1; tt_expect=16'h6667 gives tt_match=0. tt_match clears on the next start.
